// File: rtl/ps2_send.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the request-to-send,
// shifts out byte + odd parity on device clock edges, and checks the device ACK.
module ps2_send #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_kbclk_en,
    input  logic       i_ps2_dat,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic       o_timeout
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK
    } state_t;

    state_t        state;
    logic [7:0]    byte_q;
    logic          parity_q;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] timer;

    assign o_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state        <= IDLE;
            byte_q       <= '0;
            parity_q     <= 1'b0;
            bit_cnt      <= '0;
            inh_cnt      <= '0;
            timer        <= '0;
            o_ps2_clk_oe <= 1'b0;
            o_ps2_dat_oe <= 1'b0;
            o_done       <= 1'b0;
            o_ack_err    <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_ack_err <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        byte_q       <= i_byte;
                        parity_q     <= ~^i_byte;
                        bit_cnt      <= '0;
                        inh_cnt      <= '0;
                        timer        <= '0;
                        o_ps2_clk_oe <= 1'b1;
                        o_ps2_dat_oe <= 1'b0;
                        state        <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        o_ps2_dat_oe <= 1'b1;
                        state        <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                REQ: begin
                    o_ps2_clk_oe <= 1'b0;
                    timer        <= '0;
                    state        <= SEND;
                end
                SEND: begin
                    // A device edge in the would-be timeout cycle wins over the timeout.
                    if (i_kbclk_en) begin
                        timer   <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < 4'd8) begin
                            o_ps2_dat_oe <= ~byte_q[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            o_ps2_dat_oe <= ~parity_q;
                        end else begin
                            o_ps2_dat_oe <= 1'b0;
                            state        <= ACK;
                        end
                    end else if (timer == TMO_LAST) begin
                        o_timeout    <= 1'b1;
                        o_ps2_clk_oe <= 1'b0;
                        o_ps2_dat_oe <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK: begin
                    o_ps2_dat_oe <= 1'b0;
                    if (i_kbclk_en) begin
                        o_done    <= ~i_ps2_dat;
                        o_ack_err <= i_ps2_dat;
                        timer     <= '0;
                        state     <= IDLE;
                    end else if (timer == TMO_LAST) begin
                        o_timeout    <= 1'b1;
                        o_ps2_clk_oe <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    o_ps2_clk_oe <= 1'b0;
                    o_ps2_dat_oe <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
